// File: rtl/vproc_vreg_rd_seq_if.sv
// rtl/vproc_vreg_rd_seq_if.sv - request, regfile read port and output stream bundle for vproc_vreg_rd_seq
interface vproc_vreg_rd_seq_if #(
    parameter int PORT_W = 32,
    parameter int ID_W   = 3,
    parameter int ADDR_W = 7
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [4:0]        req_vreg_i;
    logic [1:0]        req_emul_i;
    logic [ID_W-1:0]   req_id_i;
    logic [ADDR_W-1:0] rf_rd_addr_o;
    logic [PORT_W-1:0] rf_rd_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [PORT_W-1:0] out_data_o;
    logic              out_last_o;
    logic [ID_W-1:0]   out_id_o;
    logic              busy_o;

    modport master (
        output req_valid_i, req_vreg_i, req_emul_i, req_id_i, rf_rd_data_i, out_ready_i,
        input  req_ready_o, rf_rd_addr_o, out_valid_o, out_data_o, out_last_o, out_id_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_vreg_i, req_emul_i, req_id_i, rf_rd_data_i, out_ready_i,
        output req_ready_o, rf_rd_addr_o, out_valid_o, out_data_o, out_last_o, out_id_o, busy_o
    );
endinterface

// File: rtl/vproc_vreg_rd_seq.sv
// rtl/vproc_vreg_rd_seq.sv - vector register group read sequencer with output FIFO
// Walks {vreg, chunk} addresses for a register group and streams captured read data downstream.
module vproc_vreg_rd_seq #(
    parameter int VREG_W     = 128,
    parameter int PORT_W     = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int ID_W       = 3
) (
    input  logic                clk_i,
    input  logic                async_rst_i,
    vproc_vreg_rd_seq_if.slave  bus
);
    localparam int CHUNKS = VREG_W / PORT_W;
    localparam int CH_W   = $clog2(CHUNKS);
    localparam int ADDR_W = 5 + CH_W;
    localparam int REM_W  = 3 + CH_W;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [REM_W-1:0]  REM_ONE  = REM_W'(1);
    localparam logic [REM_W:0]    CHUNKS_X = (REM_W + 1)'(CHUNKS);
    localparam logic [REM_W:0]    ONE_X    = (REM_W + 1)'(1);

    typedef enum logic {S_IDLE, S_READ} state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [ADDR_W-1:0] r_addr;
    logic [REM_W-1:0]  r_rem;
    logic [ID_W-1:0]   r_id;

    // Storage is sized to a power of two so the pointers index it without width games.
    logic [PORT_W-1:0] r_mem_data [2**PTR_W];
    logic              r_mem_last [2**PTR_W];
    logic [ID_W-1:0]   r_mem_id   [2**PTR_W];
    logic [PTR_W-1:0]  r_wr;
    logic [PTR_W-1:0]  r_rd;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_out_valid;
    logic              w_pop;
    logic              w_issue;
    logic              w_req_ready;
    logic              w_accept;
    logic              w_rem_zero;
    logic [REM_W-1:0]  w_rem_init;

    assign w_out_valid = (r_cnt != '0);
    assign w_pop       = w_out_valid && bus.out_ready_i;
    assign w_rem_zero  = (r_rem == '0);
    assign w_rem_init  = REM_W'((CHUNKS_X << bus.req_emul_i) - ONE_X);

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // A full FIFO may still issue when the head is leaving this cycle.
    always_comb begin
        w_state_nx  = r_state;
        w_issue     = 1'b0;
        w_req_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid_i) begin
                    w_state_nx = S_READ;
                end
            end
            S_READ: begin
                w_issue     = (r_cnt != CNT_FULL) || w_pop;
                w_req_ready = w_issue && w_rem_zero;
                if (w_issue && w_rem_zero && !bus.req_valid_i) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        w_accept = bus.req_valid_i && w_req_ready;
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            r_addr <= '0;
            r_rem  <= '0;
            r_id   <= '0;
        end else if (w_accept) begin
            r_addr <= ADDR_W'(bus.req_vreg_i) << CH_W;
            r_rem  <= w_rem_init;
            r_id   <= bus.req_id_i;
        end else if (w_issue) begin
            r_addr <= r_addr + ADDR_ONE;
            r_rem  <= r_rem - REM_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_issue) begin
            r_mem_data[r_wr] <= bus.rf_rd_data_i;
            r_mem_last[r_wr] <= w_rem_zero;
            r_mem_id[r_wr]   <= r_id;
        end
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_issue) begin
                r_wr <= (r_wr == PTR_LAST) ? '0 : r_wr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd <= (r_rd == PTR_LAST) ? '0 : r_rd + PTR_ONE;
            end
            case ({w_issue, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign bus.req_ready_o  = w_req_ready;
    assign bus.rf_rd_addr_o = r_addr;
    assign bus.out_valid_o  = w_out_valid;
    assign bus.out_data_o   = w_out_valid ? r_mem_data[r_rd] : '0;
    assign bus.out_last_o   = w_out_valid ? r_mem_last[r_rd] : 1'b0;
    assign bus.out_id_o     = w_out_valid ? r_mem_id[r_rd]   : '0;
    assign bus.busy_o       = (r_state == S_READ) || w_out_valid;
endmodule
